operand_fwd_sel: RTL and testbench
==================================

Name: operand_fwd_sel

Overview:
- Parametrised, pipelined successor to the single-cycle ALU operand-B select.
- Selects one of NSRC packed operand sources.
- Applies EX/MEM and MEM/WB forwarding to source 0 (register-file read data).
- Delivers the result through a 2-entry skid-buffered valid/ready stage between decode and execute.

Parameters:
- WIDTH, 64, operand width in bits.
- NSRC, 5, number of selectable sources (0=ReadData2, 1=ALU imm, 2=shifted, 3=mult, 4=DT addr).
- SEL_W, $clog2(NSRC), select width (derived; never overridden).
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  registered; upstream may present a beat.
- sel  in  SEL_W  source select.
- src_data  in  WIDTH*NSRC  packed sources; source i at [i*WIDTH +: WIDTH].
- rs_addr  in  RA_W  register number feeding source 0.
- exmem_wr  in  1  EX/MEM stage writes a register.
- exmem_rd  in  RA_W  EX/MEM destination register.
- exmem_data  in  WIDTH  EX/MEM result.
- memwb_wr  in  1  MEM/WB stage writes a register.
- memwb_rd  in  RA_W  MEM/WB destination register.
- memwb_data  in  WIDTH  MEM/WB result.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  selected, forwarded operand.
- out_fwd  out  2  forwarding used: 00 none, 01 EX/MEM, 10 MEM/WB.
- sel_err  out  1  sticky illegal-select flag.

Behaviour:
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Selection and forwarding are combinational on inputs at the accept edge; result is registered, so latency is 1 cycle from accept to out_valid.
- Forwarding applies only when sel==0 and rs_addr != 31 (XZR never forwarded).
  - EX/MEM hit: exmem_wr & exmem_rd==rs_addr. Has priority over MEM/WB.
  - MEM/WB hit: memwb_wr & memwb_rd==rs_addr.
  - No hit: use src_data source 0, out_fwd=00.
  - When sel != 0, out_fwd is always 00.
- Illegal select: sel >= NSRC gives data 0 and out_fwd 00, and sets sel_err; the beat still passes. sel_err clears only on reset.
- State machine (out register + skid register):
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept & drain -> ONE (new beat into out register).
    - Accept & !drain -> TWO (new beat into skid).
    - Drain only -> EMPTY.
    - Otherwise hold.
  - TWO: out_valid=1, in_ready=0. Drain -> ONE (skid moves to out). Otherwise hold.
- in_ready is registered: it equals (next_state != TWO).
- out_data and out_fwd stay stable while out_valid & !out_ready.
- Beats are never dropped or duplicated; order is preserved.
- Reset values: state EMPTY, out_valid 0, out_data 0, out_fwd 00, sel_err 0, in_ready 1 from the first cycle after reset.
- Reset mid-operation discards both entries; out_valid falls on the next edge.
- Inputs are ignored while reset_n=0.

Optional Feature:
- Macro: OPERAND_FWD_SEL_CNT_EN.
- Defined:
  - Adds outputs fwd_ex_cnt[15:0] and fwd_wb_cnt[15:0].
  - Each increments once per accepted beat with out_fwd 01 / 10 respectively.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then sel=1, src1=64'h1234, single accept with out_ready=1 -> next cycle out_valid=1, out_data=64'h1234, out_fwd=00, in_ready stays 1.
- sel=0, rs_addr=5, exmem_wr=1 rd=5 data=64'hAA, memwb_wr=1 rd=5 data=64'hBB -> out_data=64'hAA, out_fwd=01. Repeat with exmem_wr=0 -> 64'hBB, out_fwd=10.
- sel=0, rs_addr=31, exmem_wr=1 rd=31 data=64'hFF, src0=0 -> out_data=0, out_fwd=00.
- out_ready=0, three back-to-back beats 1,2,3 -> beats 1 and 2 held, in_ready=0 after the second accept, beat 3 stalled. Raising out_ready -> 1,2,3 emerge in order, none lost.
- sel=7 with NSRC=5 -> out_data=0, sel_err=1, and sel_err remains 1 across later legal beats until reset_n=0.
- Reset asserted while in state TWO -> next cycle out_valid=0, in_ready=1 after release, no stale beat emitted. With OPERAND_FWD_SEL_CNT_EN, counters also read 0.

Source files
------------

// File: rtl/operand_fwd_sel.sv
// Operand-B select with EX/MEM and MEM/WB forwarding on source 0, delivered through a 2-entry skid buffer.
// Define OPERAND_FWD_SEL_CNT_EN to add saturating forwarding-hit counters (fwd_ex_cnt, fwd_wb_cnt).
module operand_fwd_sel #(
    parameter int WIDTH = 64,
    parameter int NSRC  = 5,
    parameter int SEL_W = $clog2(NSRC),
    parameter int RA_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic [WIDTH*NSRC-1:0] src_data,
    input  logic [RA_W-1:0]       rs_addr,
    input  logic                  exmem_wr,
    input  logic [RA_W-1:0]       exmem_rd,
    input  logic [WIDTH-1:0]      exmem_data,
    input  logic                  memwb_wr,
    input  logic [RA_W-1:0]       memwb_rd,
    input  logic [WIDTH-1:0]      memwb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [1:0]            out_fwd,
`ifdef OPERAND_FWD_SEL_CNT_EN
    output logic [15:0]           fwd_ex_cnt,
    output logic [15:0]           fwd_wb_cnt,
`endif
    output logic                  sel_err
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_fwd_q, out_fwd_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [1:0]       skid_fwd_q, skid_fwd_d;
    logic             sel_err_q, sel_err_d;

    logic             accept, drain;
    logic [WIDTH-1:0] beat_data;
    logic [1:0]       beat_fwd;
    logic             beat_legal;

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    // Illegal selects fall through the loop and leave data at zero.
    always_comb begin
        beat_data  = '0;
        beat_fwd   = 2'b00;
        beat_legal = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel == SEL_W'(i)) begin
                beat_data  = src_data[i*WIDTH +: WIDTH];
                beat_legal = 1'b1;
            end
        end
        if (sel == '0 && rs_addr != RA_W'(31)) begin
            if (exmem_wr && exmem_rd == rs_addr) begin
                beat_data = exmem_data;
                beat_fwd  = 2'b01;
            end else if (memwb_wr && memwb_rd == rs_addr) begin
                beat_data = memwb_data;
                beat_fwd  = 2'b10;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_fwd_d   = out_fwd_q;
        skid_data_d = skid_data_q;
        skid_fwd_d  = skid_fwd_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d    = ONE;
                    out_data_d = beat_data;
                    out_fwd_d  = beat_fwd;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    out_data_d = beat_data;
                    out_fwd_d  = beat_fwd;
                end else if (accept) begin
                    state_d     = TWO;
                    skid_data_d = beat_data;
                    skid_fwd_d  = beat_fwd;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    state_d    = ONE;
                    out_data_d = skid_data_q;
                    out_fwd_d  = skid_fwd_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != TWO);
        sel_err_d   = sel_err_q | (accept & ~beat_legal);
    end

`ifdef OPERAND_FWD_SEL_CNT_EN
    logic [15:0] fwd_ex_cnt_q, fwd_ex_cnt_d;
    logic [15:0] fwd_wb_cnt_q, fwd_wb_cnt_d;

    always_comb begin
        fwd_ex_cnt_d = fwd_ex_cnt_q;
        fwd_wb_cnt_d = fwd_wb_cnt_q;
        if (accept && beat_fwd == 2'b01 && fwd_ex_cnt_q != 16'hFFFF)
            fwd_ex_cnt_d = fwd_ex_cnt_q + 16'd1;
        if (accept && beat_fwd == 2'b10 && fwd_wb_cnt_q != 16'hFFFF)
            fwd_wb_cnt_d = fwd_wb_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fwd_ex_cnt_q <= '0;
            fwd_wb_cnt_q <= '0;
        end else begin
            fwd_ex_cnt_q <= fwd_ex_cnt_d;
            fwd_wb_cnt_q <= fwd_wb_cnt_d;
        end
    end

    assign fwd_ex_cnt = fwd_ex_cnt_q;
    assign fwd_wb_cnt = fwd_wb_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_data_q  <= '0;
            out_fwd_q   <= 2'b00;
            skid_data_q <= '0;
            skid_fwd_q  <= 2'b00;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            out_data_q  <= out_data_d;
            out_fwd_q   <= out_fwd_d;
            skid_data_q <= skid_data_d;
            skid_fwd_q  <= skid_fwd_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_fwd   = out_fwd_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_operand_fwd_sel.sv
// Scoreboard bench for operand_fwd_sel: directed beats push expectations, a negedge monitor pops and compares on every drain.
module tb_operand_fwd_sel;

   localparam int WIDTH = 64;
   localparam int NSRC  = 5;
   localparam int SEL_W = 3;
   localparam int RA_W  = 5;

   logic                  clk;
   logic                  reset_n;
   logic                  in_valid;
   logic                  in_ready;
   logic [SEL_W-1:0]      sel;
   logic [WIDTH*NSRC-1:0] src_data;
   logic [RA_W-1:0]       rs_addr;
   logic                  exmem_wr;
   logic [RA_W-1:0]       exmem_rd;
   logic [WIDTH-1:0]      exmem_data;
   logic                  memwb_wr;
   logic [RA_W-1:0]       memwb_rd;
   logic [WIDTH-1:0]      memwb_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH-1:0]      out_data;
   logic [1:0]            out_fwd;
   logic                  sel_err;
`ifdef OPERAND_FWD_SEL_CNT_EN
   logic [15:0]           fwd_ex_cnt;
   logic [15:0]           fwd_wb_cnt;
`endif

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [1:0]       fwd;
   } exp_t;

   exp_t scoreboard[$];
   int   checks = 0;
   int   errors = 0;

   operand_fwd_sel #(
      .WIDTH(WIDTH),
      .NSRC (NSRC),
      .RA_W (RA_W)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .src_data  (src_data),
      .rs_addr   (rs_addr),
      .exmem_wr  (exmem_wr),
      .exmem_rd  (exmem_rd),
      .exmem_data(exmem_data),
      .memwb_wr  (memwb_wr),
      .memwb_rd  (memwb_rd),
      .memwb_data(memwb_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_fwd   (out_fwd),
`ifdef OPERAND_FWD_SEL_CNT_EN
      .fwd_ex_cnt(fwd_ex_cnt),
      .fwd_wb_cnt(fwd_wb_cnt),
`endif
      .sel_err   (sel_err)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the stimulus ever wedges
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: bumps the counters and reports any difference
   task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual, input logic [WIDTH-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic setSource(input int idx, input logic [WIDTH-1:0] val);
      src_data[idx*WIDTH +: WIDTH] = val;
   endtask

   // Drive one beat from a negedge, wait for in_ready within a budget, record the expectation at the accept edge
   task automatic applyStimulus(input logic [SEL_W-1:0] s, input logic [RA_W-1:0] rs,
                                input logic ex_wr, input logic [RA_W-1:0] ex_rd, input logic [WIDTH-1:0] ex_d,
                                input logic wb_wr, input logic [RA_W-1:0] wb_rd, input logic [WIDTH-1:0] wb_d,
                                input logic [WIDTH-1:0] exp_d, input logic [1:0] exp_f);
      exp_t e;
      int   waited;
      sel        = s;
      rs_addr    = rs;
      exmem_wr   = ex_wr;
      exmem_rd   = ex_rd;
      exmem_data = ex_d;
      memwb_wr   = wb_wr;
      memwb_rd   = wb_rd;
      memwb_data = wb_d;
      in_valid   = 1'b1;
      waited     = 0;
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, waited);
      end else begin
         @(posedge clk);
         e.data = exp_d;
         e.fwd  = exp_f;
         scoreboard.push_back(e);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Every drain pops the oldest expected beat; unexpected beats count as failures
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat: got data %0h fwd %0b, expected no beat", out_data, out_fwd);
         end else begin
            exp_t e;
            e = scoreboard.pop_front();
            checkOutput("beat_data", out_data, e.data);
            checkOutput("beat_fwd", {62'd0, out_fwd}, {62'd0, e.fwd});
         end
      end
   end

   // Directed sequence covering select, forwarding priority, XZR, backpressure, illegal select and reset
   initial begin
      reset_n    = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      sel        = '0;
      src_data   = '0;
      rs_addr    = '0;
      exmem_wr   = 1'b0;
      exmem_rd   = '0;
      exmem_data = '0;
      memwb_wr   = 1'b0;
      memwb_rd   = '0;
      memwb_data = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
      checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
      checkOutput("reset_out_data", out_data, 64'd0);
      checkOutput("reset_out_fwd", {62'd0, out_fwd}, 64'd0);
      checkOutput("reset_sel_err", {63'd0, sel_err}, 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      setSource(0, 64'h77);
      setSource(1, 64'h1234);
      setSource(2, 64'h2222);
      setSource(3, 64'h3333);
      setSource(4, 64'h4444);

      applyStimulus(3'd1, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h1234, 2'b00);
      checkOutput("single_out_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("single_in_ready", {63'd0, in_ready}, 64'd1);

      applyStimulus(3'd0, 5'd5, 1'b1, 5'd5, 64'hAA, 1'b1, 5'd5, 64'hBB, 64'hAA, 2'b01);
      applyStimulus(3'd0, 5'd5, 1'b0, 5'd5, 64'hAA, 1'b1, 5'd5, 64'hBB, 64'hBB, 2'b10);
      setSource(0, 64'h0);
      applyStimulus(3'd0, 5'd31, 1'b1, 5'd31, 64'hFF, 1'b1, 5'd31, 64'hEE, 64'h0, 2'b00);
      setSource(0, 64'h55);
      applyStimulus(3'd0, 5'd5, 1'b1, 5'd6, 64'hAA, 1'b1, 5'd4, 64'hBB, 64'h55, 2'b00);
      applyStimulus(3'd2, 5'd5, 1'b1, 5'd5, 64'hAA, 1'b1, 5'd5, 64'hBB, 64'h2222, 2'b00);
      waitCycles(2);

      out_ready = 1'b0;
      setSource(3, 64'h1);
      applyStimulus(3'd3, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h1, 2'b00);
      setSource(3, 64'h2);
      applyStimulus(3'd3, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h2, 2'b00);
      checkOutput("full_in_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("full_out_valid", {63'd0, out_valid}, 64'd1);
      setSource(3, 64'h3);
      in_valid = 1'b1;
      waitCycles(2);
      checkOutput("stall_in_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("stall_hold_data", out_data, 64'h1);
      out_ready = 1'b1;
      applyStimulus(3'd3, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h3, 2'b00);
      waitCycles(3);
      checkOutput("drain_empty", {63'd0, out_valid}, 64'd0);

      applyStimulus(3'd7, 5'd5, 1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'h0, 64'h0, 2'b00);
      checkOutput("illegal_sel_err", {63'd0, sel_err}, 64'd1);
      applyStimulus(3'd4, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h4444, 2'b00);
      waitCycles(2);
      checkOutput("sticky_sel_err", {63'd0, sel_err}, 64'd1);
`ifdef OPERAND_FWD_SEL_CNT_EN
      checkOutput("fwd_ex_cnt", {48'd0, fwd_ex_cnt}, 64'd1);
      checkOutput("fwd_wb_cnt", {48'd0, fwd_wb_cnt}, 64'd1);
`endif

      out_ready = 1'b0;
      applyStimulus(3'd1, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h1234, 2'b00);
      applyStimulus(3'd2, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 64'h2222, 2'b00);
      checkOutput("pre_reset_full", {63'd0, in_ready}, 64'd0);
      reset_n = 1'b0;
      scoreboard.delete();
      @(negedge clk);
      checkOutput("midreset_out_valid", {63'd0, out_valid}, 64'd0);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("postreset_in_ready", {63'd0, in_ready}, 64'd1);
      checkOutput("postreset_sel_err", {63'd0, sel_err}, 64'd0);
`ifdef OPERAND_FWD_SEL_CNT_EN
      checkOutput("postreset_ex_cnt", {48'd0, fwd_ex_cnt}, 64'd0);
      checkOutput("postreset_wb_cnt", {48'd0, fwd_wb_cnt}, 64'd0);
`endif
      waitCycles(3);
      checkOutput("no_stale_beat", {63'd0, out_valid}, 64'd0);

      applyStimulus(3'd0, 5'd9, 1'b0, 5'd0, 64'h0, 1'b1, 5'd9, 64'hCAFE, 64'hCAFE, 2'b10);
      waitCycles(3);
      checkOutput("scoreboard_drained", 64'(scoreboard.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
